game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_if.sv | 26 ++
 rtl/game_sequencer.sv | 161 ++++++++++++++++
 tb/tb_game_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Control bundle between the snake game sequencer and its surrounding logic.
// The master side drives pulses and buttons; the slave side (the sequencer) drives status.
interface game_sequencer_if;
  logic       frame_pulse;
  logic       start_btn;
  logic       pause_btn;
  logic       self_bite;
  logic       apple_eaten;
  logic       move_ack;
  logic       move_req;
  logic       game_rst;
  logic [1:0] game_state;
  logic [2:0] level;
  logic [7:0] score;
  logic       overrun;

  modport master (
    output frame_pulse, start_btn, pause_btn, self_bite, apple_eaten, move_ack,
    input  move_req, game_rst, game_state, level, score, overrun
  );

  modport slave (
    input  frame_pulse, start_btn, pause_btn, self_bite, apple_eaten, move_ack,
    output move_req, game_rst, game_state, level, score, overrun
  );
endinterface

// File: rtl/game_sequencer.sv
// Snake game sequencer: game state machine, frame-paced move requests with
// handshake, apple scoring and level-driven speed-up.
module game_sequencer #(
  parameter int BASE_PERIOD      = 16,
  parameter int MIN_PERIOD       = 2,
  parameter int APPLES_PER_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  game_sequencer_if.slave   bus
);

  localparam int PW = $clog2(BASE_PERIOD) + 1;
  localparam int AW = $clog2(APPLES_PER_LEVEL + 1);
  localparam logic [AW-1:0] APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t          state_r, state_n;
  logic            start_prev_r, pause_prev_r;
  logic [PW-1:0]   frame_cnt_r, frame_cnt_n;
  logic [AW-1:0]   apple_cnt_r, apple_cnt_n;
  logic [2:0]      level_r, level_n;
  logic [7:0]      score_r, score_n;
  logic            move_req_r, move_req_n;
  logic            game_rst_r, game_rst_n;
  logic            overrun_r, overrun_n;

  logic            start_edge_s, pause_edge_s;
  logic [PW-1:0]   period_s;
  logic            slot_due_s;

  assign start_edge_s = bus.start_btn & ~start_prev_r;
  assign pause_edge_s = bus.pause_btn & ~pause_prev_r;
  // Level only advances while period exceeds MIN_PERIOD, so the shift never undershoots it.
  assign period_s     = PW'(BASE_PERIOD) >> level_r;
  assign slot_due_s   = (frame_cnt_r >= (period_s - PW'(1)));

  // Next-state and next-output computation for every register.
  always_comb begin
    state_n     = state_r;
    frame_cnt_n = frame_cnt_r;
    apple_cnt_n = apple_cnt_r;
    level_n     = level_r;
    score_n     = score_r;
    move_req_n  = move_req_r;
    game_rst_n  = 1'b0;
    overrun_n   = overrun_r;

    // Ack retires a pending request in any state; a stray ack is harmless.
    if (move_req_r && bus.move_ack) begin
      move_req_n = 1'b0;
    end else begin
      move_req_n = move_req_r;
    end

    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_edge_s) begin
          state_n     = ST_PLAY;
          game_rst_n  = 1'b1;
          frame_cnt_n = '0;
          apple_cnt_n = '0;
          level_n     = 3'd0;
          score_n     = 8'd0;
          overrun_n   = 1'b0;
        end else begin
          state_n = state_r;
        end
      end
      ST_PLAY: begin
        if (pause_edge_s) begin
          state_n = ST_PAUSE;
        end else if (bus.self_bite) begin
          state_n    = ST_OVER;
          move_req_n = 1'b0;
        end else begin
          if (bus.frame_pulse) begin
            if (slot_due_s) begin
              frame_cnt_n = '0;
              if (move_req_r) begin
                overrun_n = 1'b1;
              end else begin
                move_req_n = 1'b1;
              end
            end else begin
              frame_cnt_n = frame_cnt_r + PW'(1);
            end
          end else begin
            frame_cnt_n = frame_cnt_r;
          end
          if (bus.apple_eaten) begin
            score_n = (score_r == 8'd255) ? 8'd255 : score_r + 8'd1;
            if (apple_cnt_r == APPLE_LAST) begin
              apple_cnt_n = '0;
              if (period_s > PW'(MIN_PERIOD)) begin
                level_n = level_r + 3'd1;
              end else begin
                level_n = level_r;
              end
            end else begin
              apple_cnt_n = apple_cnt_r + AW'(1);
            end
          end else begin
            apple_cnt_n = apple_cnt_r;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_edge_s) begin
          state_n = ST_PLAY;
        end else begin
          state_n = ST_PAUSE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset primes the button history high so held buttons are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      start_prev_r <= 1'b1;
      pause_prev_r <= 1'b1;
      frame_cnt_r  <= '0;
      apple_cnt_r  <= '0;
      level_r      <= 3'd0;
      score_r      <= 8'd0;
      move_req_r   <= 1'b0;
      game_rst_r   <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      start_prev_r <= bus.start_btn;
      pause_prev_r <= bus.pause_btn;
      frame_cnt_r  <= frame_cnt_n;
      apple_cnt_r  <= apple_cnt_n;
      level_r      <= level_n;
      score_r      <= score_n;
      move_req_r   <= move_req_n;
      game_rst_r   <= game_rst_n;
      overrun_r    <= overrun_n;
    end
  end

  assign bus.move_req   = move_req_r;
  assign bus.game_rst   = game_rst_r;
  assign bus.game_state = state_r;
  assign bus.level      = level_r;
  assign bus.score      = score_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: linear stimulus with hand-computed expectations.
module tb_game_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  game_sequencer_if gs_if ();

  game_sequencer #(
    .BASE_PERIOD(16),
    .MIN_PERIOD(2),
    .APPLES_PER_LEVEL(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(gs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      gs_if.frame_pulse = 1'b1;
      tick();
      gs_if.frame_pulse = 1'b0;
      tick();
    end
  endtask

  task automatic apples(input int n);
    for (int i = 0; i < n; i++) begin
      gs_if.apple_eaten = 1'b1;
      tick();
      gs_if.apple_eaten = 1'b0;
      tick();
    end
  endtask

  task automatic ack();
    gs_if.move_ack = 1'b1;
    tick();
    gs_if.move_ack = 1'b0;
  endtask

  task automatic press_pause();
    gs_if.pause_btn = 1'b1;
    tick();
    gs_if.pause_btn = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    gs_if.frame_pulse = 1'b0;
    gs_if.start_btn   = 1'b0;
    gs_if.pause_btn   = 1'b0;
    gs_if.self_bite   = 1'b0;
    gs_if.apple_eaten = 1'b0;
    gs_if.move_ack    = 1'b0;
    tick();
    tick();
    check("rst_state",    {6'd0, gs_if.game_state}, 8'd0);
    check("rst_move_req", {7'd0, gs_if.move_req},   8'd0);
    check("rst_game_rst", {7'd0, gs_if.game_rst},   8'd0);
    check("rst_score",    gs_if.score,              8'd0);
    check("rst_level",    {5'd0, gs_if.level},      8'd0);
    check("rst_overrun",  {7'd0, gs_if.overrun},    8'd0);

    // Start from IDLE: one-cycle game_rst, first move on the 16th frame.
    rst = 1'b1;
    tick();
    gs_if.start_btn = 1'b1;
    tick();
    check("start_game_rst", {7'd0, gs_if.game_rst},   8'd1);
    check("start_state",    {6'd0, gs_if.game_state}, 8'd1);
    gs_if.start_btn = 1'b0;
    tick();
    check("game_rst_1cyc",  {7'd0, gs_if.game_rst},   8'd0);
    frames(15);
    check("mreq_before_16", {7'd0, gs_if.move_req},   8'd0);
    frames(1);
    check("mreq_at_16",     {7'd0, gs_if.move_req},   8'd1);

    // Ack withheld: overrun on the 32nd frame, request held until ack.
    frames(15);
    check("ovr_before_32",  {7'd0, gs_if.overrun},    8'd0);
    frames(1);
    check("ovr_at_32",      {7'd0, gs_if.overrun},    8'd1);
    check("mreq_held_32",   {7'd0, gs_if.move_req},   8'd1);
    frames(4);
    check("mreq_held_36",   {7'd0, gs_if.move_req},   8'd1);
    ack();
    check("mreq_drop_ack",  {7'd0, gs_if.move_req},   8'd0);
    ack();
    check("stray_ack",      {7'd0, gs_if.move_req},   8'd0);
    check("ovr_sticky",     {7'd0, gs_if.overrun},    8'd1);

    // Six apples: level 1, period 8. Frame counter sits at 4.
    apples(6);
    check("lvl_after_6",    {5'd0, gs_if.level},      8'd1);
    check("score_after_6",  gs_if.score,              8'd6);
    frames(3);
    check("l1_cnt7_no_req", {7'd0, gs_if.move_req},   8'd0);
    frames(1);
    check("l1_slot",        {7'd0, gs_if.move_req},   8'd1);
    ack();
    frames(7);
    check("l1_int_7",       {7'd0, gs_if.move_req},   8'd0);
    frames(1);
    check("l1_int_8",       {7'd0, gs_if.move_req},   8'd1);
    ack();

    // 24 apples total: level saturates at 3, period 2.
    apples(18);
    check("lvl_after_24",   {5'd0, gs_if.level},      8'd3);
    check("score_after_24", gs_if.score,              8'd24);
    apples(6);
    check("lvl_after_30",   {5'd0, gs_if.level},      8'd3);
    check("score_after_30", gs_if.score,              8'd30);
    frames(1);
    check("l3_int_1",       {7'd0, gs_if.move_req},   8'd0);
    frames(1);
    check("l3_int_2",       {7'd0, gs_if.move_req},   8'd1);
    ack();

    // Start ignored in PLAY; self_bite ends the game and holds score/level.
    gs_if.start_btn = 1'b1;
    tick();
    check("start_in_play",  {7'd0, gs_if.game_rst},   8'd0);
    gs_if.start_btn = 1'b0;
    tick();
    gs_if.self_bite = 1'b1;
    tick();
    gs_if.self_bite = 1'b0;
    check("over_state",     {6'd0, gs_if.game_state}, 8'd3);
    check("over_score",     gs_if.score,              8'd30);
    check("over_level",     {5'd0, gs_if.level},      8'd3);

    // New game, score 5, bite coinciding with apple while a request is pending.
    gs_if.start_btn = 1'b1;
    tick();
    check("restart_score",  gs_if.score,              8'd0);
    check("restart_level",  {5'd0, gs_if.level},      8'd0);
    check("restart_ovr",    {7'd0, gs_if.overrun},    8'd0);
    gs_if.start_btn = 1'b0;
    tick();
    apples(5);
    frames(16);
    check("pend_before_bite", {7'd0, gs_if.move_req}, 8'd1);
    gs_if.self_bite   = 1'b1;
    gs_if.apple_eaten = 1'b1;
    tick();
    gs_if.self_bite   = 1'b0;
    gs_if.apple_eaten = 1'b0;
    check("bite_state",     {6'd0, gs_if.game_state}, 8'd3);
    check("bite_score",     gs_if.score,              8'd5);
    check("bite_mreq",      {7'd0, gs_if.move_req},   8'd0);
    frames(20);
    check("over_frames",    {7'd0, gs_if.move_req},   8'd0);
    press_pause();
    check("pause_in_over",  {6'd0, gs_if.game_state}, 8'd3);

    // Pause mid-count, 40 frames frozen, resume from count 5.
    gs_if.start_btn = 1'b1;
    tick();
    gs_if.start_btn = 1'b0;
    tick();
    frames(5);
    press_pause();
    check("paused_state",   {6'd0, gs_if.game_state}, 8'd2);
    frames(40);
    check("paused_mreq",    {7'd0, gs_if.move_req},   8'd0);
    press_pause();
    check("resumed_state",  {6'd0, gs_if.game_state}, 8'd1);
    frames(10);
    check("resume_cnt15",   {7'd0, gs_if.move_req},   8'd0);
    frames(1);
    check("resume_slot",    {7'd0, gs_if.move_req},   8'd1);
    press_pause();
    check("pause_pend",     {7'd0, gs_if.move_req},   8'd1);
    ack();
    check("pause_ack",      {7'd0, gs_if.move_req},   8'd0);
    press_pause();

    // Pause edge beats a coincident self_bite.
    gs_if.pause_btn = 1'b1;
    gs_if.self_bite = 1'b1;
    tick();
    gs_if.pause_btn = 1'b0;
    gs_if.self_bite = 1'b0;
    check("pause_vs_bite",  {6'd0, gs_if.game_state}, 8'd2);
    tick();
    press_pause();
    frames(16);
    check("pre_rst_mreq",   {7'd0, gs_if.move_req},   8'd1);

    // Reset mid-handshake with start held across its release.
    rst = 1'b0;
    gs_if.start_btn = 1'b1;
    tick();
    check("rst_abort_mreq", {7'd0, gs_if.move_req},   8'd0);
    check("rst_abort_st",   {6'd0, gs_if.game_state}, 8'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("held_start_idle", {6'd0, gs_if.game_state}, 8'd0);
    gs_if.start_btn = 1'b0;
    tick();
    gs_if.start_btn = 1'b1;
    tick();
    check("repress_state",  {6'd0, gs_if.game_state}, 8'd1);
    check("repress_grst",   {7'd0, gs_if.game_rst},   8'd1);
    gs_if.start_btn = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
